pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameters SHALL be:
  - MEM_TIMEOUT, 15: maximum MEM wait cycles before forced release.
  - CNT_W, 32: width of the performance counters.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  - clk_i  in  1  single clock; all state on rising edge.
  - rst_i  in  1  reset; asynchronous, active-high.
  - ID_rs1_i  in  5  rs1 address of instruction in ID.
  - ID_rs2_i  in  5  rs2 address of instruction in ID.
  - ID_uses_rs2_i  in  1  instruction in ID reads rs2.
  - EX_rd_i  in  5  destination of instruction in EX.
  - EX_rd_wr_en_i  in  1  EX instruction writes rd.
  - EX_is_load_i  in  1  EX instruction is a load.
  - ID_pc_src_i  in  1  branch/jump taken, resolved in ID.
  - MEM_req_i  in  1  MEM stage has an active data-memory access.
  - MEM_ready_i  in  1  data memory completes the access this cycle.
  - IF_stall_o  out  1  hold PC.
  - ID_stall_o  out  1  hold IF/ID register.
  - EX_stall_o  out  1  hold ID/EX register.
  - MEM_stall_o  out  1  hold EX/MEM register.
  - IF_flush_o  out  1  squash IF/ID contents (wrong-path fetch).
  - EX_bubble_o  out  1  load NOP into ID/EX.
  - WB_bubble_o  out  1  load NOP into MEM/WB.
  - err_timeout_o  out  1  sticky MEM timeout flag.
  - stall_cnt_o  out  CNT_W  cycles with any stall asserted.
  - flush_cnt_o  out  CNT_W  cycles with IF_flush_o asserted.

Function
REQ-003 FSM SHALL have states S_RUN, S_LOAD_USE and S_MEM_WAIT; the state register is the only control state besides wait_cnt and the two counters.
REQ-004 mem_wait SHALL equal MEM_req_i & !MEM_ready_i.
REQ-005 load_use SHALL equal EX_is_load_i & EX_rd_wr_en_i & (EX_rd_i != 0) & ((EX_rd_i == ID_rs1_i) | (ID_uses_rs2_i & (EX_rd_i == ID_rs2_i))).
REQ-006 Priority SHALL be mem_wait > load_use > branch flush, evaluated combinationally each cycle.
REQ-007 When mem_wait is true in S_RUN or S_MEM_WAIT, outputs SHALL be:
  - IF_stall_o, ID_stall_o, EX_stall_o and MEM_stall_o = 1.
  - WB_bubble_o = 1.
  - IF_flush_o = 0 and EX_bubble_o = 0.
  - next state = S_MEM_WAIT.
REQ-008 In S_MEM_WAIT, wait_cnt SHALL increment every cycle and clear on exit.
REQ-009 On MEM_ready_i in S_MEM_WAIT, the FSM SHALL return to S_RUN with zero added latency: stalls deassert in the same cycle.
REQ-010 When wait_cnt reaches MEM_TIMEOUT, the block SHALL:
  - set err_timeout_o (sticky until reset);
  - deassert all stalls for that cycle;
  - assert WB_bubble_o;
  - return to S_RUN.
REQ-011 When load_use is true in S_RUN without mem_wait, outputs SHALL be IF_stall_o = 1, ID_stall_o = 1, EX_bubble_o = 1 and IF_flush_o = 0, with next state S_LOAD_USE.
REQ-012 S_LOAD_USE SHALL last exactly one cycle:
  - load_use is ignored in it, so the load can advance to MEM and be forwarded;
  - it exits to S_MEM_WAIT if mem_wait, else to S_RUN.
REQ-013 When ID_pc_src_i is true and no stall is asserted in the current cycle, IF_flush_o SHALL be 1.
REQ-014 A branch SHALL never flush while ID is stalled; the held branch re-asserts ID_pc_src_i once released.
REQ-015 load_use coincident with mem_wait SHALL be deferred: EX is held, so it is re-detected after release.
REQ-016 stall_cnt_o SHALL increment in every cycle in which any *_stall_o is 1.
REQ-017 flush_cnt_o SHALL increment in every cycle in which IF_flush_o is 1.
REQ-018 Both counters SHALL saturate at all-ones and never wrap.
REQ-019 All outputs other than the counters and err_timeout_o SHALL be combinational from the inputs and the state.

Reset
REQ-020 rst_i high SHALL asynchronously force:
  - state = S_RUN;
  - wait_cnt = 0, stall_cnt_o = 0, flush_cnt_o = 0;
  - err_timeout_o = 0.
REQ-021 While rst_i is high, all stall, flush and bubble outputs SHALL be 0.
REQ-022 Reset asserted mid-wait or mid-stall SHALL abandon the operation, with no residual stall after release.

Structure
REQ-023 A shared package pipeline_ctrl_pkg SHALL hold the state enum and the MEM_TIMEOUT default.
REQ-024 The saturating counter SHALL be one sub-module, sat_counter, instantiated twice.
REQ-025 Target size SHALL be 150-250 lines of RTL.

Verification
REQ-026 Load-use:
  - stimulus: EX load with EX_rd_i = 5 and ID_rs1_i = 5;
  - response: IF_stall_o, ID_stall_o and EX_bubble_o are 1 for exactly 1 cycle; stall_cnt_o = 1.
REQ-027 Load to x0:
  - stimulus: EX_rd_i = 0, ID_rs1_i = 0;
  - response: no stall.
REQ-028 Unused rs2:
  - stimulus: ID_rs2_i match with ID_uses_rs2_i = 0;
  - response: no stall.
REQ-029 MEM wait:
  - stimulus: MEM_req_i = 1 with MEM_ready_i low for 3 cycles, then high;
  - response: all four stalls and WB_bubble_o are high for 3 cycles, released on the ready cycle; stall_cnt_o = 3.
REQ-030 Branch:
  - stimulus: ID_pc_src_i = 1 with no hazard, then ID_pc_src_i = 1 with load_use;
  - response: IF_flush_o = 1 and flush_cnt_o = 1 in the first case; IF_flush_o = 0 and stall in the second.
REQ-031 Timeout:
  - stimulus: MEM_ready_i held low for 20 cycles;
  - response: release at wait_cnt = 15; err_timeout_o = 1 and remains 1 until rst_i.
REQ-032 Reset mid-wait:
  - stimulus: rst_i pulse in S_MEM_WAIT;
  - response: outputs go to 0 immediately, before any clock edge.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
//------------------------------------------------------------------------------
// pipeline_ctrl_pkg : shared state encoding and defaults for the hazard control
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_LOAD_USE = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_t;

  localparam int c_MEM_TIMEOUT_DEF = 15;
  localparam int c_CNT_W_DEF       = 32;

  // Width needed to hold a wait count up to and including the timeout value.
  function automatic int wait_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
//------------------------------------------------------------------------------
// sat_counter : event counter that sticks at all-ones instead of wrapping
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
//------------------------------------------------------------------------------
// pipeline_hazard_ctrl : stall/flush/bubble control for a 5-stage pipeline
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = c_MEM_TIMEOUT_DEF,
  parameter int CNT_W       = c_CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_rs1_i,
  input  logic [4:0]       ID_rs2_i,
  input  logic             ID_uses_rs2_i,
  input  logic [4:0]       EX_rd_i,
  input  logic             EX_rd_wr_en_i,
  input  logic             EX_is_load_i,
  input  logic             ID_pc_src_i,
  input  logic             MEM_req_i,
  input  logic             MEM_ready_i,
  output logic             IF_stall_o,
  output logic             ID_stall_o,
  output logic             EX_stall_o,
  output logic             MEM_stall_o,
  output logic             IF_flush_o,
  output logic             EX_bubble_o,
  output logic             WB_bubble_o,
  output logic             err_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int                  c_WAIT_W  = wait_width(MEM_TIMEOUT);
  localparam logic [c_WAIT_W-1:0] c_TIMEOUT = c_WAIT_W'(MEM_TIMEOUT);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [c_WAIT_W-1:0] w_wait_cnt_nxt;
  logic                r_err;

  logic w_mem_wait;
  logic w_load_use;
  logic w_timeout;
  logic w_stall_all;
  logic w_stall_front;
  logic w_ex_bubble;
  logic w_wb_bubble;
  logic w_flush;
  logic w_any_stall;

  assign w_mem_wait = MEM_req_i & ~MEM_ready_i;
  assign w_load_use = EX_is_load_i & EX_rd_wr_en_i & (EX_rd_i != 5'd0) &
                      ((EX_rd_i == ID_rs1_i) | (ID_uses_rs2_i & (EX_rd_i == ID_rs2_i)));
  assign w_timeout  = w_mem_wait & (r_wait_cnt == c_TIMEOUT);

  always_comb begin
    w_stall_all    = 1'b0;
    w_stall_front  = 1'b0;
    w_ex_bubble    = 1'b0;
    w_wb_bubble    = 1'b0;
    w_state_nxt    = S_RUN;
    w_wait_cnt_nxt = '0;
    if (w_mem_wait) begin
      // A timed-out access still bubbles WB but lets the pipeline move on.
      w_wb_bubble = 1'b1;
      if (!w_timeout) begin
        w_stall_all    = 1'b1;
        w_state_nxt    = S_MEM_WAIT;
        w_wait_cnt_nxt = r_wait_cnt + 1'b1;
      end
    end else if (w_load_use && (r_state != S_LOAD_USE)) begin
      w_stall_front = 1'b1;
      w_ex_bubble   = 1'b1;
      w_state_nxt   = S_LOAD_USE;
    end
  end

  // A taken branch only squashes the fetch when ID is actually advancing.
  assign w_flush     = ID_pc_src_i & ~w_stall_all & ~w_stall_front;
  assign w_any_stall = ~rst_i & (w_stall_all | w_stall_front);

  assign IF_stall_o    = w_any_stall;
  assign ID_stall_o    = w_any_stall;
  assign EX_stall_o    = ~rst_i & w_stall_all;
  assign MEM_stall_o   = ~rst_i & w_stall_all;
  assign IF_flush_o    = ~rst_i & w_flush;
  assign EX_bubble_o   = ~rst_i & w_ex_bubble;
  assign WB_bubble_o   = ~rst_i & w_wb_bubble;
  assign err_timeout_o = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .i_inc (w_any_stall),
    .o_cnt (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .i_inc (IF_flush_o),
    .o_cnt (flush_cnt_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
//------------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl : directed and random checks against a cycle model
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int TO   = 15;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [4:0]    ID_rs1_i, ID_rs2_i, EX_rd_i;
  logic          ID_uses_rs2_i, EX_rd_wr_en_i, EX_is_load_i, ID_pc_src_i;
  logic          MEM_req_i, MEM_ready_i;
  logic          IF_stall_o, ID_stall_o, EX_stall_o, MEM_stall_o;
  logic          IF_flush_o, EX_bubble_o, WB_bubble_o, err_timeout_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  wire [7:0] obs_vec = {IF_stall_o, ID_stall_o, EX_stall_o, MEM_stall_o,
                        IF_flush_o, EX_bubble_o, WB_bubble_o, err_timeout_o};

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: consecutive MEM stall cycles, pending load-use, counters.
  int            m_waits, m_sc, m_fc, n_waits, n_sc, n_fc;
  bit            m_lu_pend, m_err, n_lu, n_err;
  logic [7:0]    exp_vec;
  logic [CW-1:0] exp_sc, exp_fc;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i), .ID_uses_rs2_i(ID_uses_rs2_i),
    .EX_rd_i(EX_rd_i), .EX_rd_wr_en_i(EX_rd_wr_en_i), .EX_is_load_i(EX_is_load_i),
    .ID_pc_src_i(ID_pc_src_i), .MEM_req_i(MEM_req_i), .MEM_ready_i(MEM_ready_i),
    .IF_stall_o(IF_stall_o), .ID_stall_o(ID_stall_o), .EX_stall_o(EX_stall_o),
    .MEM_stall_o(MEM_stall_o), .IF_flush_o(IF_flush_o), .EX_bubble_o(EX_bubble_o),
    .WB_bubble_o(WB_bubble_o), .err_timeout_o(err_timeout_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    m_waits = 0; m_sc = 0; m_fc = 0; m_lu_pend = 0; m_err = 0;
  endtask

  task automatic model_eval();
    bit mw, lu, s4, s2, fl, eb, wb;
    mw = MEM_req_i && !MEM_ready_i;
    lu = EX_is_load_i && EX_rd_wr_en_i && (EX_rd_i != 0) &&
         ((EX_rd_i == ID_rs1_i) || (ID_uses_rs2_i && (EX_rd_i == ID_rs2_i)));
    s4 = 0; s2 = 0; fl = 0; eb = 0; wb = 0;
    n_waits = 0; n_lu = 0; n_err = m_err;
    if (mw) begin
      wb = 1;
      if (m_waits >= TO) begin
        fl = ID_pc_src_i; n_err = 1;
      end else begin
        s4 = 1; n_waits = m_waits + 1;
      end
    end else if (lu && !m_lu_pend) begin
      s2 = 1; eb = 1; n_lu = 1;
    end else begin
      fl = ID_pc_src_i;
    end
    if (rst_i) {s4, s2, fl, eb, wb} = '0;
    exp_vec = {s4 | s2, s4 | s2, s4, s4, fl, eb, wb, m_err};
    exp_sc  = CW'(m_sc);
    exp_fc  = CW'(m_fc);
    n_sc    = ((s4 || s2) && m_sc < CMAX) ? m_sc + 1 : m_sc;
    n_fc    = (fl && m_fc < CMAX) ? m_fc + 1 : m_fc;
  endtask

  task automatic advance();
    @(posedge clk_i);
    if (rst_i) model_reset();
    else begin
      m_waits = n_waits; m_lu_pend = n_lu; m_err = n_err; m_sc = n_sc; m_fc = n_fc;
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic we, input logic ld,
                       input logic pc, input logic req, input logic rdy);
    @(negedge clk_i);
    ID_rs1_i = rs1; ID_rs2_i = rs2; ID_uses_rs2_i = u2; EX_rd_i = rd;
    EX_rd_wr_en_i = we; EX_is_load_i = ld; ID_pc_src_i = pc;
    MEM_req_i = req; MEM_ready_i = rdy;
    #1;
    model_eval();
  endtask

  task automatic set_idle();
    ID_rs1_i = 5'd1; ID_rs2_i = 5'd2; ID_uses_rs2_i = 0; EX_rd_i = 5'd0;
    EX_rd_wr_en_i = 0; EX_is_load_i = 0; ID_pc_src_i = 0; MEM_req_i = 0; MEM_ready_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    set_idle();
    rst_i = 1;
    #1 model_reset();
    @(negedge clk_i);
    rst_i = 0;
  endtask

  task automatic test_reset();
    ID_rs1_i = 5'd5; ID_rs2_i = 5'd0; ID_uses_rs2_i = 0; EX_rd_i = 5'd5;
    EX_rd_wr_en_i = 1; EX_is_load_i = 1; ID_pc_src_i = 1; MEM_req_i = 1; MEM_ready_i = 0;
    #1 rst_i = 1;
    @(posedge clk_i);
    #1 model_reset();
    model_eval();
    n_cmp++;
    if ({obs_vec, stall_cnt_o, flush_cnt_o} !== {exp_vec, exp_sc, exp_fc}) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b/%0d/%0d want %b/%0d/%0d",
               obs_vec, stall_cnt_o, flush_cnt_o, exp_vec, exp_sc, exp_fc);
    end
    n_cmp++;
    if (obs_vec !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_all_zero: got %b want 00000000", obs_vec);
    end
    @(negedge clk_i);
    set_idle();
    rst_i = 0;
  endtask

  task automatic test_load_use();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(5'd5, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0);
      else       drive(5'd5, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
      n_cmp++;
      if ({obs_vec, stall_cnt_o, flush_cnt_o} !== {exp_vec, exp_sc, exp_fc}) begin
        n_fail++;
        $display("FAIL load_use c%0d: got %b/%0d/%0d want %b/%0d/%0d",
                 i, obs_vec, stall_cnt_o, flush_cnt_o, exp_vec, exp_sc, exp_fc);
      end
      if (i == 0) begin
        n_cmp++;
        if (obs_vec !== 8'b1100_0100) begin
          n_fail++;
          $display("FAIL load_use_first: got %b want 11000100", obs_vec);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (stall_cnt_o !== CW'(1)) begin
          n_fail++;
          $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cnt_o);
        end
      end
      advance();
    end
  endtask

  task automatic test_no_hazard();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive(5'd0, 5'd3, 0, 5'd0, 1, 1, 0, 0, 0);
        1:       drive(5'd3, 5'd7, 0, 5'd7, 1, 1, 0, 0, 0);
        default: drive(5'd3, 5'd7, 1, 5'd7, 1, 1, 0, 0, 0);
      endcase
      n_cmp++;
      if ({obs_vec, stall_cnt_o, flush_cnt_o} !== {exp_vec, exp_sc, exp_fc}) begin
        n_fail++;
        $display("FAIL no_hazard c%0d: got %b/%0d/%0d want %b/%0d/%0d",
                 i, obs_vec, stall_cnt_o, flush_cnt_o, exp_vec, exp_sc, exp_fc);
      end
      n_cmp++;
      if (IF_stall_o !== (i == 2)) begin
        n_fail++;
        $display("FAIL no_hazard_stall c%0d: got %b want %b", i, IF_stall_o, (i == 2));
      end
      advance();
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 1, (i == 3));
      else       drive(5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 0, 0);
      n_cmp++;
      if ({obs_vec, stall_cnt_o, flush_cnt_o} !== {exp_vec, exp_sc, exp_fc}) begin
        n_fail++;
        $display("FAIL mem_wait c%0d: got %b/%0d/%0d want %b/%0d/%0d",
                 i, obs_vec, stall_cnt_o, flush_cnt_o, exp_vec, exp_sc, exp_fc);
      end
      n_cmp++;
      if (obs_vec[7:1] !== ((i < 3) ? 7'b1111_001 : 7'b0000_000)) begin
        n_fail++;
        $display("FAIL mem_wait_pattern c%0d: got %b", i, obs_vec[7:1]);
      end
      if (i == 4) begin
        n_cmp++;
        if (stall_cnt_o !== CW'(3)) begin
          n_fail++;
          $display("FAIL mem_wait_stall_cnt: got %0d want 3", stall_cnt_o);
        end
      end
      advance();
    end
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i == 1) drive(5'd4, 5'd0, 0, 5'd4, 1, 1, 1, 0, 0);
      else        drive(5'd4, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0);
      n_cmp++;
      if ({obs_vec, stall_cnt_o, flush_cnt_o} !== {exp_vec, exp_sc, exp_fc}) begin
        n_fail++;
        $display("FAIL branch c%0d: got %b/%0d/%0d want %b/%0d/%0d",
                 i, obs_vec, stall_cnt_o, flush_cnt_o, exp_vec, exp_sc, exp_fc);
      end
      if (i == 1) begin
        n_cmp++;
        if ({IF_flush_o, ID_stall_o, flush_cnt_o} !== {1'b0, 1'b1, CW'(1)}) begin
          n_fail++;
          $display("FAIL branch_hold: got flush=%b stall=%b fcnt=%0d want 0 1 1",
                   IF_flush_o, ID_stall_o, flush_cnt_o);
        end
      end
      advance();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 22; i++) begin
      if (i < 21) drive(5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 1, (i == 20));
      else        drive(5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 0, 0);
      n_cmp++;
      if ({obs_vec, stall_cnt_o, flush_cnt_o} !== {exp_vec, exp_sc, exp_fc}) begin
        n_fail++;
        $display("FAIL timeout c%0d: got %b/%0d/%0d want %b/%0d/%0d",
                 i, obs_vec, stall_cnt_o, flush_cnt_o, exp_vec, exp_sc, exp_fc);
      end
      if (i == 15) begin
        n_cmp++;
        if (obs_vec[7:1] !== 7'b0000_001) begin
          n_fail++;
          $display("FAIL timeout_release: got %b want 0000001", obs_vec[7:1]);
        end
      end
      advance();
    end
    for (int i = 0; i < 5; i++) begin
      drive(5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 0, 0);
      advance();
    end
    n_cmp++;
    if (err_timeout_o !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: got %b want 1", err_timeout_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 1, 0);
      n_cmp++;
      if ({obs_vec, stall_cnt_o, flush_cnt_o} !== {exp_vec, exp_sc, exp_fc}) begin
        n_fail++;
        $display("FAIL mid_wait c%0d: got %b/%0d/%0d want %b/%0d/%0d",
                 i, obs_vec, stall_cnt_o, flush_cnt_o, exp_vec, exp_sc, exp_fc);
      end
      advance();
    end
    @(negedge clk_i);
    #2 rst_i = 1;
    #1;
    n_cmp++;
    if ({obs_vec, stall_cnt_o, flush_cnt_o} !== {8'h00, CW'(0), CW'(0)}) begin
      n_fail++;
      $display("FAIL mid_wait_async_reset: got %b/%0d/%0d want 00000000/0/0",
               obs_vec, stall_cnt_o, flush_cnt_o);
    end
    model_reset();
    @(negedge clk_i);
    set_idle();
    rst_i = 0;
    drive(5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({obs_vec, stall_cnt_o, flush_cnt_o} !== {exp_vec, exp_sc, exp_fc}) begin
      n_fail++;
      $display("FAIL mid_wait_after: got %b/%0d/%0d want %b/%0d/%0d",
               obs_vec, stall_cnt_o, flush_cnt_o, exp_vec, exp_sc, exp_fc);
    end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)));
      n_cmp++;
      if ({obs_vec, stall_cnt_o, flush_cnt_o} !== {exp_vec, exp_sc, exp_fc}) begin
        n_fail++;
        $display("FAIL random c%0d: got %b/%0d/%0d want %b/%0d/%0d",
                 i, obs_vec, stall_cnt_o, flush_cnt_o, exp_vec, exp_sc, exp_fc);
      end
      advance();
    end
    n_cmp++;
    if (stall_cnt_o !== CW'(CMAX)) begin
      n_fail++;
      $display("FAIL random_saturate: got %0d want %0d", stall_cnt_o, CMAX);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mem_wait();
    test_branch();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
